dmem_mmio: RTL and testbench

- Data-side neighbour of the single-cycle core. Consumes the core's memwrite, aluout (address) and writedata, and returns readdata in the same cycle.
- Contains a word RAM plus a small memory-mapped I/O region:
  - a TX FIFO that streams words out over a valid/ready handshake;
  - a status register;
  - a loadable free-running cycle counter.
- Sits between the core and the board/testbench, replacing a plain data memory.

---
 rtl/dmem_mmio_pkg.sv | 31 +++
 rtl/io_fifo.sv | 55 +++++
 rtl/dmem_mmio.sv | 100 ++++++++++
 tb/tb_dmem_mmio.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the data-memory / MMIO block.
// Address map, STATUS bit layout and the decoded-region enum.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] MMIO_CYCLE  = 32'hFFFF_0008;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TX,
        REG_STATUS,
        REG_CYCLE,
        REG_NONE
    } region_t;

    // Word address only: the byte-offset bits never take part in decode.
    function automatic region_t decode_region(input logic [31:2] wa);
        if (!wa[31])                     return REG_RAM;
        else if (wa == MMIO_TXDATA[31:2]) return REG_TX;
        else if (wa == MMIO_STATUS[31:2]) return REG_STATUS;
        else if (wa == MMIO_CYCLE[31:2])  return REG_CYCLE;
        else                              return REG_NONE;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with a separate occupancy counter.
// Push when full and pop when empty are silently ignored.
module io_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word RAM plus TX FIFO,
// STATUS and a loadable cycle counter, all single-cycle accesses.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    region_t           region;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              tx_push;
    logic [31:0]       status;
    logic [31:0]       cycle;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];
    assign region  = decode_region(addr[31:2]);
    assign ram_idx = addr[RAM_AW+1:2];
    assign tx_push = memwrite && (region == REG_TX);

    io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (writedata),
        .pop       (out_ready && out_valid),
        .head      (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid = !empty;

    always_comb begin
        status                       = '0;
        status[ST_COUNT_LSB +: 8]    = 8'(count);
        status[ST_OVF]               = overflow;
        status[ST_FULL]              = full;
        status[ST_EMPTY]             = empty;
    end

    always_comb begin
        readdata = '0;
        case (region)
            REG_RAM:    readdata = ram[ram_idx];
            REG_STATUS: readdata = status;
            REG_CYCLE:  readdata = cycle;
            default:    readdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (memwrite && (region == REG_RAM)) ram[ram_idx] <= writedata;
    end

    // Clear is tested first so it takes priority over a drop on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (memwrite && (region == REG_STATUS) && writedata[ST_OVF]) begin
            overflow <= 1'b0;
        end else if (tx_push && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle <= '0;
        end else if (memwrite && (region == REG_CYCLE)) begin
            cycle <= writedata;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus random
// accesses checked against a queue/array reference model.
module tb_dmem_mmio;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC = 32'hFFFF_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        overflow;

    always #5 clk = ~clk;

    dmem_mmio #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    int unsigned nassert = 0;
    int unsigned nfail   = 0;

    logic [31:0] ram_m [64];
    logic [31:0] q [$];
    logic        ovf_m;
    logic [31:0] cyc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] wa;
        int          sz;
        logic [7:0]  sz8;
        wa  = {a[31:2], 2'b00};
        sz  = q.size();
        sz8 = sz[7:0];
        if (!a[31])      return ram_m[a[7:2]];
        if (wa == A_ST)  return {16'h0, sz8, 5'b0, ovf_m, (sz == 4), (sz == 0)};
        if (wa == A_CYC) return cyc_m;
        return 32'h0;
    endfunction

    // One bus cycle: check outputs before the edge, then advance the model.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        logic [31:0] wa;
        int          sz;
        memwrite  = we;
        addr      = a;
        writedata = wd;
        out_ready = rdy;
        #1;
        chk("readdata", readdata, model_read(a));
        chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() != 0)});
        chk("out_data", out_data, (q.size() != 0) ? q[0] : 32'h0);
        chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
        @(posedge clk);
        wa = {a[31:2], 2'b00};
        sz = q.size();
        if (rdy && sz != 0) void'(q.pop_front());
        if (we && !a[31]) ram_m[a[7:2]] = wd;
        if (we && wa == A_TX) begin
            if (sz < 4) q.push_back(wd);
            else ovf_m = 1'b1;
        end
        if (we && wa == A_ST && wd[2]) ovf_m = 1'b0;
        cyc_m = (we && wa == A_CYC) ? wd : cyc_m + 32'd1;
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memwrite = 1'b0;
        addr     = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] wa;
        int unsigned op;

        reset = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0; out_ready = 1'b0;
        ovf_m = 1'b0; cyc_m = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ovf", {31'b0, overflow}, 32'h0);
        peek("rst_status", A_ST, 32'h0000_0001);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 64; i++) begin
            r = $urandom;
            step(1'b1, 32'(i * 4), r, 1'b0);
        end

        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        peek("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        peek("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);

        step(1'b1, A_TX, 32'd1, 1'b0);
        step(1'b1, A_TX, 32'd2, 1'b0);
        step(1'b1, A_TX, 32'd3, 1'b0);
        peek("st_three", A_ST, 32'h0000_0300);
        peek("tx_read", A_TX, 32'h0);
        chk("drain1", out_data, 32'd1);
        step(1'b0, A_ST, 32'h0, 1'b1);
        chk("drain2", out_data, 32'd2);
        step(1'b0, A_ST, 32'h0, 1'b1);
        chk("drain3", out_data, 32'd3);
        step(1'b0, A_ST, 32'h0, 1'b1);
        chk("drained_valid", {31'b0, out_valid}, 32'h0);
        peek("st_empty", A_ST, 32'h0000_0001);

        for (int i = 0; i < 5; i++) step(1'b1, A_TX, 32'h100 + 32'(i), 1'b0);
        chk("ovf_set", {31'b0, overflow}, 32'h1);
        peek("st_ovf", A_ST, 32'h0000_0406);
        step(1'b1, A_ST, 32'h4, 1'b0);
        chk("ovf_clr", {31'b0, overflow}, 32'h0);
        peek("st_full", A_ST, 32'h0000_0402);
        chk("ovf_head", out_data, 32'h100);
        repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1);

        step(1'b1, A_TX, 32'h11, 1'b0);
        step(1'b1, A_TX, 32'h22, 1'b0);
        step(1'b1, A_TX, 32'hA5, 1'b1);
        peek("pp_count", A_ST, 32'h0000_0200);
        chk("pp_head1", out_data, 32'h22);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("pp_head2", out_data, 32'hA5);
        step(1'b0, 32'h0, 32'h0, 1'b1);

        step(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
        peek("cyc_load", A_CYC, 32'hFFFF_FFFE);
        step(1'b0, A_CYC, 32'h0, 1'b0);
        peek("cyc_max", A_CYC, 32'hFFFF_FFFF);
        step(1'b0, A_CYC, 32'h0, 1'b0);
        peek("cyc_wrap", A_CYC, 32'h0000_0000);

        repeat (300) begin
            op = $urandom_range(0, 7);
            r  = $urandom;
            case (op)
                0: step(1'b1, {1'b0, r[30:0]}, $urandom, 1'($urandom_range(0, 1)));
                1: step(1'b0, {1'b0, r[30:0]}, 32'h0, 1'($urandom_range(0, 1)));
                2: step(1'b1, A_TX | {30'b0, r[1:0]}, $urandom, 1'($urandom_range(0, 1)));
                3: step(1'b0, A_ST, r, 1'($urandom_range(0, 1)));
                4: step(1'b1, A_ST, r, 1'($urandom_range(0, 1)));
                5: step(1'b0, A_CYC, r, 1'($urandom_range(0, 1)));
                6: step(1'($urandom_range(0, 3) == 0), A_CYC, r, 1'($urandom_range(0, 1)));
                default: begin
                    a  = 32'h8000_0000 | r;
                    wa = {a[31:2], 2'b00};
                    if (wa == A_TX || wa == A_ST || wa == A_CYC) a = 32'hFFFF_000C;
                    step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
                end
            endcase
        end

        while (q.size() != 0) step(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, A_TX, 32'h200 + 32'(i), 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("amid_valid", {31'b0, out_valid}, 32'h0);
        chk("amid_data", out_data, 32'h0);
        chk("amid_ovf", {31'b0, overflow}, 32'h0);
        q.delete();
        ovf_m = 1'b0;
        cyc_m = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        peek("post_status", A_ST, 32'h0000_0001);
        peek("post_cyc0", A_CYC, 32'h0);
        step(1'b0, A_CYC, 32'h0, 1'b0);
        step(1'b0, A_CYC, 32'h0, 1'b0);
        peek("post_cyc2", A_CYC, 32'h2);
        step(1'b1, A_TX, 32'h33, 1'b0);
        step(1'b0, A_ST, 32'h0, 1'b1);
        step(1'b0, A_ST, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
